mux_16x1_arbiter: RTL and testbench
===================================

# mux_16x1_arbiter

Round-robin arbiter and sequencer for the 16:1 single-bit output mux. Up to 16 requesters share the mux output. The block grants one requester at a time and drives the mux `enable` and `sel` lines directly. It sits between the requester bank and the mux, and it guarantees at least one idle (`enable`=0) cycle between owners.

## Interface
- `HOLD_MAX`, 8: maximum number of consecutive GRANT cycles for one owner; legal range 1..255; used only when `MUX_ARB_TIMEOUT_EN` is defined.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `req`  input  16  request vector; bit i = requester i wants the mux.
- `done`  input  1  the current owner releases the mux; ignored outside GRANT.
- `enable`  output  1  mux enable; 1 only in GRANT.
- `sel`  output  4  mux select = index of the current owner.
- `gnt`  output  16  one-hot grant; all-zero outside GRANT.
- `busy`  output  1  1 in GRANT and GAP.
- `tmo`  output  1  one-cycle pulse in the GAP cycle that follows a timeout release.

## Operation
- States: IDLE, GRANT, GAP. All outputs are registered.
- Round-robin pointer `ptr` (4 bits):
  - Search starts at `ptr` and goes upward, wrapping 15→0.
  - The first set `req` bit wins.
  - On every grant, `ptr` = winner+1 mod 16.
- IDLE:
  - If `req`≠0 → GRANT with the winner as owner.
  - Otherwise stay in IDLE.
- GRANT:
  - `enable`=1, `sel`=owner, `gnt`=1<<owner.
  - Release on any of: `done`=1, `req[owner]`=0, or timeout (hold counter = `HOLD_MAX`).
  - Release → GAP.
  - If several release causes occur in the same cycle, there is one release; `tmo` is set only if timeout is among them.
- GAP:
  - Outputs are forced low; `sel` holds the last owner.
  - Arbitration runs on `req` in this cycle: `req`≠0 → GRANT, else → IDLE.
  - The previous owner can win again only if no other requester is found first from `ptr`.
- Hold counter (8 bits):
  - Loads 1 on entry to GRANT and increments each GRANT cycle.
  - Compared against `HOLD_MAX`.
- Reset:
  - `rst_n`=0 at any edge, including mid-GRANT: state=IDLE, `ptr`=0, counter=0.
  - Output reset values: `enable`=0, `sel`=0, `gnt`=0, `busy`=0, `tmo`=0.
- `req` changes in GRANT for non-owners have no effect until the next arbitration.

## Timing
- Grant latency: `req` seen in IDLE at edge k → `enable`/`gnt`/`sel` valid after edge k (cycle k+1).
- Release: release cause sampled at edge t → `enable`=0 in cycle t+1 (GAP).
- Next owner: if `req`≠0 at edge t+1, the next owner is granted in cycle t+2.
- Minimum handover = 1 dead cycle.
- Timeout: an owner that holds without `done` gets exactly `HOLD_MAX` enabled cycles.
- With `HOLD_MAX`=1, every grant lasts exactly one cycle.
- `done` in IDLE or GAP is ignored; it is not latched.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - The hold counter and timeout release are present.
  - `tmo` is functional.
- `MUX_ARB_TIMEOUT_EN` undefined:
  - No counter.
  - GRANT ends only on `done` or `req[owner]` dropping.
  - `tmo` is tied to 0.
  - `HOLD_MAX` is unused.

## Structure
- Package `mux_arb_pkg`:
  - Constants `N_REQ`=16 and `SEL_W`=4.
  - State enum typedef `arb_state_t` {IDLE, GRANT, GAP}.
- Sub-module `rr_pick16`:
  - Combinational round-robin finder.
  - Inputs: `req[15:0]`, `ptr[3:0]`. Outputs: `valid`, `idx[3:0]`.
  - Instantiated once.
- Top holds the FSM, `ptr`, the counter and the output registers.

## Test plan
- Reset/idle: `rst_n`=0 for 2 cycles with `req`=16'hFFFF → `enable`=0, `sel`=0, `gnt`=0, `busy`=0; release reset → `gnt`=16'h0001 and `sel`=0 one cycle later.
- Round-robin: `req`=16'h8001 held, `done` pulsed 1 cycle after each grant → `sel` sequence 0, 15, 0, 15, with one GAP cycle (`enable`=0) between each.
- Wrap/pointer: grant `sel`=14, then `req`=16'h4002 → next `sel`=1, not 14.
- Timeout (macro on, `HOLD_MAX`=3): `req`=16'h0010, no `done` → `enable` high exactly 3 cycles, `tmo`=1 in the following GAP cycle, then re-grant of `sel`=4.
- Request drop: owner 5 lowers `req[5]` mid-GRANT → GAP next cycle; `done` asserted in that GAP → no effect.
- Reset mid-grant: `rst_n`=0 while `sel`=9 is granted → next cycle all outputs 0; after release with `req`=16'h0600 → `sel`=9 (`ptr` restarted at 0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and FSM state type for the 16:1 mux arbiter.
// Contents: N_REQ (requester count), SEL_W (select width), arb_state_t.
// Latency/backpressure: not applicable (declarations only).
package mux_arb_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin finder: first set req bit at or above ptr, wrapping 15->0.
// Ports: req[15:0], ptr[3:0] in; valid (any req set), idx[3:0] (winner) out.
// Latency: zero (pure combinational); no backpressure.
module rr_pick16
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest set bit to ptr is
  // the last one written and therefore wins. cand wraps naturally at 4 bits.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_16x1_arbiter.sv
// Round-robin arbiter/sequencer driving a 16:1 mux: one owner at a time, >=1 idle cycle between owners.
// Ports: clk, rst_n (sync, active-low), req[15:0], done in; enable, sel[3:0], gnt[15:0], busy, tmo out (all registered).
// Latency: grant one cycle after req seen; owner timeout (HOLD_MAX cycles) only when MUX_ARB_TIMEOUT_EN is defined.
module mux_16x1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             enable,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             tmo
);

  arb_state_t       state, nstate;
  logic [SEL_W-1:0] ptr, nptr;
  logic [SEL_W-1:0] nowner;
  logic             ntmo;
  logic             rel;
  logic             tmo_hit;
  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // cnt equals the number of GRANT cycles already spent by the current
  // owner including this one, so hitting HOLD_MAX here gives exactly
  // HOLD_MAX enabled cycles.
  assign tmo_hit = (state == GRANT) && (cnt == HOLD_MAX[7:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (nstate == GRANT) begin
      cnt <= (state == GRANT) ? cnt + 8'd1 : 8'd1;
    end else begin
      cnt <= '0;
    end
  end
`else
  logic [7:0] unused_hold_max;
  assign unused_hold_max = HOLD_MAX[7:0];
  assign tmo_hit         = 1'b0;
`endif

  // sel doubles as the owner register: it holds the last owner through
  // GAP and IDLE, so GRANT can compare req[sel] directly.
  always_comb begin
    nstate = state;
    nptr   = ptr;
    nowner = sel;
    ntmo   = 1'b0;
    rel    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          nstate = GRANT;
          nowner = pick_idx;
          nptr   = pick_idx + 4'd1;
        end
      end
      GRANT: begin
        rel = done | ~req[sel] | tmo_hit;
        if (rel) begin
          nstate = GAP;
          ntmo   = tmo_hit;
        end
      end
      GAP: begin
        if (pick_vld) begin
          nstate = GRANT;
          nowner = pick_idx;
          nptr   = pick_idx + 4'd1;
        end else begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      enable <= 1'b0;
      sel    <= '0;
      gnt    <= '0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      state  <= nstate;
      ptr    <= nptr;
      enable <= (nstate == GRANT);
      sel    <= nowner;
      gnt    <= (nstate == GRANT) ? (N_REQ'(1) << nowner) : '0;
      busy   <= (nstate != IDLE);
      tmo    <= ntmo;
    end
  end

endmodule

// File: tb/tb_mux_16x1_arbiter.sv
// Directed self-checking bench for mux_16x1_arbiter (HOLD_MAX=3).
// Timeout expectations follow MUX_ARB_TIMEOUT_EN.
// Inputs driven 1 time unit after the rising edge, outputs checked there too.
module tb_mux_16x1_arbiter;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic        enable;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        tmo;

  int vectors;
  int miscompares;

  mux_16x1_arbiter #(.HOLD_MAX(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .done   (done),
    .enable (enable),
    .sel    (sel),
    .gnt    (gnt),
    .busy   (busy),
    .tmo    (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks every output against one expected vector.
  task automatic chk_all(input string tag, input logic e_en, input logic [3:0] e_sel,
                         input logic [15:0] e_gnt, input logic e_busy, input logic e_tmo);
    chk({tag, ".enable"}, 32'(enable), 32'(e_en));
    chk({tag, ".sel"},    32'(sel),    32'(e_sel));
    chk({tag, ".gnt"},    32'(gnt),    32'(e_gnt));
    chk({tag, ".busy"},   32'(busy),   32'(e_busy));
    chk({tag, ".tmo"},    32'(tmo),    32'(e_tmo));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;

    // Reset with all requesters active.
    step();
    step();
    chk_all("reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("first_grant", 1'b1, 4'd0, 16'h0001, 1'b1, 1'b0);

    // Round robin between 0 and 15 with done pulses.
    req  = 16'h8001;
    done = 1'b1;
    step();
    chk_all("rr_gap0", 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("rr_g15a", 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_all("rr_gap1", 1'b0, 4'd15, 16'h0000, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("rr_g0", 1'b1, 4'd0, 16'h0001, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk("rr_gap2.enable", 32'(enable), 32'd0);
    done = 1'b0;
    step();
    chk_all("rr_g15b", 1'b1, 4'd15, 16'h8000, 1'b1, 1'b0);

    // Wrap: owner 14, then pointer (15) must pick 1 before 14.
    req = 16'h0000;
    step();
    chk("drop15.enable", 32'(enable), 32'd0);
    step();
    chk_all("to_idle", 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0);
    req = 16'h4000;
    step();
    chk_all("g14", 1'b1, 4'd14, 16'h4000, 1'b1, 1'b0);
    req  = 16'h4002;
    done = 1'b1;
    step();
    chk_all("gap14", 1'b0, 4'd14, 16'h0000, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("wrap_g1", 1'b1, 4'd1, 16'h0002, 1'b1, 1'b0);

    // Timeout with HOLD_MAX=3 on owner 4.
    req = 16'h0000;
    step();
    step();
    chk("idle_pre_tmo.busy", 32'(busy), 32'd0);
    req = 16'h0010;
    step();
    chk_all("tmo_c1", 1'b1, 4'd4, 16'h0010, 1'b1, 1'b0);
    step();
    chk("tmo_c2.enable", 32'(enable), 32'd1);
    step();
    chk("tmo_c3.enable", 32'(enable), 32'd1);
    step();
    chk_all("tmo_gap", !TMO_ON, 4'd4, TMO_ON ? 16'h0000 : 16'h0010, 1'b1, TMO_ON);
    step();
    chk_all("tmo_regrant", 1'b1, 4'd4, 16'h0010, 1'b1, 1'b0);

    // Request drop by owner 5; done in GAP is ignored and not latched.
    req = 16'h0000;
    step();
    step();
    req = 16'h0020;
    step();
    chk_all("g5", 1'b1, 4'd5, 16'h0020, 1'b1, 1'b0);
    step();
    chk("g5_hold.enable", 32'(enable), 32'd1);
    req = 16'h0000;
    step();
    chk_all("drop5_gap", 1'b0, 4'd5, 16'h0000, 1'b1, 1'b0);
    req  = 16'h0020;
    done = 1'b1;
    step();
    chk_all("gap_done_ignored", 1'b1, 4'd5, 16'h0020, 1'b1, 1'b0);
    done = 1'b0;
    step();
    chk_all("done_not_latched", 1'b1, 4'd5, 16'h0020, 1'b1, 1'b0);

    // Reset while owner 9 holds; pointer restarts at 0.
    req = 16'h0000;
    step();
    step();
    req = 16'h0200;
    step();
    chk_all("g9", 1'b1, 4'd9, 16'h0200, 1'b1, 1'b0);
    rst_n = 1'b0;
    step();
    chk_all("midgrant_reset", 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    req   = 16'h0600;
    step();
    chk_all("ptr_restart", 1'b1, 4'd9, 16'h0200, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
